// File: rtl/navibot_pkg.sv
// Shared constants and types for the navibot telemetry transmitter.
package navibot_pkg;

  localparam logic [7:0]  SyncByte = 8'hA5;
  localparam int unsigned FrameLen = 5;
  localparam int unsigned StatusW  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/navibot_telemetry_tx_uart_tx_byte.sv
// 8N1 byte serialiser; done strobes on the last cycle of the stop bit so the
// next byte can start with no idle gap.
module uart_tx_byte
  import navibot_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       uart_tx,
  output logic       done
);

  localparam int unsigned BaudW = $clog2(BAUD_DIV);

  tx_state_e        state;
  logic [BaudW-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             baud_end;

  assign baud_end = (baud_cnt == BaudW'(BAUD_DIV - 1));
  assign done     = (state == StStop) && baud_end;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        StIdle: begin
          baud_cnt <= '0;
          if (start) begin
            state   <= StStart;
            uart_tx <= 1'b0;
            shift   <= data;
          end
        end
        StStart: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= StData;
            uart_tx  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        StData: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state   <= StStop;
              uart_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        StStop: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (start) begin
              state   <= StStart;
              uart_tx <= 1'b0;
              shift   <= data;
            end else begin
              state <= StIdle;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/navibot_telemetry_tx.sv
// Telemetry frame sequencer: triggers, pending follow-up, snapshot, byte mux
// and checksum feeding a single byte serialiser.
module navibot_telemetry_tx
  import navibot_pkg::*;
#(
  parameter int unsigned BAUD_DIV      = 868,
  parameter int unsigned REPORT_PERIOD = 50_000_000
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               send_req,
  input  logic [StatusW-1:0] status,
  input  logic [7:0]         speed,
  output logic               uart_tx,
  output logic               busy,
  output logic [7:0]         frame_seq
);

  logic [StatusW-1:0] status_q;
  logic [31:0]        period_cnt;
  logic               tick;
  logic               trigger;

  logic               launch_q;
  logic               busy_q;
  logic               pending_q;
  logic [2:0]         byte_idx;
  logic [7:0]         frame_seq_q;
  logic [StatusW-1:0] snap_status;
  logic [7:0]         snap_speed;
  logic [7:0]         snap_seq;

  logic               byte_done;
  logic               frame_end;
  logic               in_flight;
  logic               idle_go;
  logic               restart;
  logic               tx_start;
  logic [2:0]         next_idx;
  logic [7:0]         tx_data;

  assign tick    = (REPORT_PERIOD != 0) && (period_cnt == REPORT_PERIOD - 1);
  assign trigger = send_req || tick || (status != status_q);

  // launch_q covers the one cycle between accepting a trigger and the start bit
  assign in_flight = busy_q || launch_q;
  assign idle_go   = !in_flight && trigger;
  assign frame_end = busy_q && byte_done && (byte_idx == 3'(FrameLen - 1));
  assign restart   = frame_end && (pending_q || trigger);
  assign tx_start  = launch_q || restart || (busy_q && byte_done && !frame_end);
  assign next_idx  = (launch_q || frame_end) ? 3'd0 : byte_idx + 3'd1;

  always_comb begin
    tx_data = SyncByte;
    case (next_idx)
      3'd0:    tx_data = SyncByte;
      3'd1:    tx_data = snap_seq;
      3'd2:    tx_data = {{(8 - StatusW){1'b0}}, snap_status};
      3'd3:    tx_data = snap_speed;
      default: tx_data = snap_seq ^ {{(8 - StatusW){1'b0}}, snap_status} ^ snap_speed;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      status_q   <= '0;
      period_cnt <= '0;
    end else begin
      status_q <= status;
      if (REPORT_PERIOD == 0 || tick) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      launch_q    <= 1'b0;
      busy_q      <= 1'b0;
      pending_q   <= 1'b0;
      byte_idx    <= '0;
      frame_seq_q <= '0;
      snap_status <= '0;
      snap_speed  <= '0;
      snap_seq    <= '0;
    end else begin
      launch_q <= idle_go;

      if (idle_go) begin
        snap_status <= status;
        snap_speed  <= speed;
        snap_seq    <= frame_seq_q;
      end else if (restart) begin
        snap_status <= status;
        snap_speed  <= speed;
        snap_seq    <= frame_seq_q + 8'd1;
      end

      if (restart) begin
        pending_q <= 1'b0;
      end else if (in_flight && trigger) begin
        pending_q <= 1'b1;
      end

      if (launch_q) begin
        busy_q <= 1'b1;
      end else if (frame_end && !restart) begin
        busy_q <= 1'b0;
      end

      if (launch_q || frame_end) begin
        byte_idx <= '0;
      end else if (busy_q && byte_done) begin
        byte_idx <= byte_idx + 3'd1;
      end

      if (frame_end) begin
        frame_seq_q <= frame_seq_q + 8'd1;
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx_byte (
    .clk_in (clk_in),
    .rst    (rst),
    .start  (tx_start),
    .data   (tx_data),
    .uart_tx(uart_tx),
    .done   (byte_done)
  );

  assign busy      = busy_q;
  assign frame_seq = frame_seq_q;

endmodule

// File: tb/tb_navibot_telemetry_tx.sv
// Bench for navibot_telemetry_tx: a line decoder pops expected frame bytes
// from a scoreboard; a second instance checks periodic frame timing.
module tb_navibot_telemetry_tx;

  localparam int unsigned Baud = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_p = 1'b1;
  logic       send_req = 1'b0;
  logic [4:0] status = 5'h00;
  logic [7:0] speed = 8'h00;
  logic       tx, busy;
  logic [7:0] seq;
  logic       tx_p, busy_p;
  logic [7:0] seq_p;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_seq;

  always #5 clk = ~clk;

  navibot_telemetry_tx #(
    .BAUD_DIV     (Baud),
    .REPORT_PERIOD(0)
  ) dut (
    .clk_in   (clk),
    .rst      (rst),
    .send_req (send_req),
    .status   (status),
    .speed    (speed),
    .uart_tx  (tx),
    .busy     (busy),
    .frame_seq(seq)
  );

  navibot_telemetry_tx #(
    .BAUD_DIV     (Baud),
    .REPORT_PERIOD(1000)
  ) dut_p (
    .clk_in   (clk),
    .rst      (rst_p),
    .send_req (1'b0),
    .status   (5'h00),
    .speed    (8'h00),
    .uart_tx  (tx_p),
    .busy     (busy_p),
    .frame_seq(seq_p)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] s, input logic [4:0] st, input logic [7:0] sp);
    exp_q.push_back(8'hA5);
    exp_q.push_back(s);
    exp_q.push_back({3'b000, st});
    exp_q.push_back(sp);
    exp_q.push_back(s ^ {3'b000, st} ^ sp);
  endtask

  // kind 1: three extra requests mid-frame; kind 2: status change mid-frame
  task automatic mid_action(input int kind, input int k);
    if (kind == 1) send_req = (k == 20 || k == 60 || k == 100);
    else if (kind == 2 && k == 30) status = 5'h02;
  endtask

  // Caller drives the trigger in the current cycle.
  task automatic frame_run(input string tag, input int kind, input int exp_len);
    int len;
    tick();
    send_req = 1'b0;
    check_eq({tag, "_launch_busy"}, busy, 1'b0);
    tick();
    check_eq({tag, "_start_bit"}, tx, 1'b0);
    check_eq({tag, "_busy_rise"}, busy, 1'b1);
    len = 0;
    while (busy === 1'b1 && len < 2000) begin
      mid_action(kind, len);
      tick();
      len++;
    end
    send_req = 1'b0;
    check_eq({tag, "_busy_len"}, len, exp_len);
  endtask

  // Line decoder: detect start on a falling edge, sample each bit's first negedge.
  int         mcnt = 0;
  logic [7:0] mbyte;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mcnt = 0;
      end else if (mcnt == 0) begin
        if (tx === 1'b0) begin
          mcnt  = 1;
          mbyte = '0;
        end
      end else begin
        if (mcnt % Baud == 0 && mcnt <= 8 * Baud) mbyte[mcnt / Baud - 1] = tx;
        if (mcnt == 9 * Baud) begin
          check_eq("stop_bit", tx, 1'b1);
          if (exp_q.size() == 0) check_eq("sb_avail", exp_q.size(), 1);
          else check_eq("byte", mbyte, exp_q.pop_front());
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
    end
  end

  int   cyc_p = 0;
  int   nrise = 0;
  logic busy_p_d = 1'b0;
  initial begin
    @(negedge rst_p);
    forever begin
      @(posedge clk);
      #1;
      cyc_p++;
      if (busy_p && !busy_p_d) begin
        if (nrise < 3) begin
          check_eq("per_time", cyc_p, 1001 + 1000 * nrise);
          check_eq("per_seq", seq_p, nrise);
        end
        nrise++;
      end
      busy_p_d = busy_p;
    end
  end

  initial begin
    m_seq = 8'h00;
    repeat (4) tick();
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_seq", seq, 8'h00);
    rst   = 1'b0;
    rst_p = 1'b0;
    repeat (3) tick();
    check_eq("idle_tx", tx, 1'b1);

    // Known frame A5 00 13 80 93
    status   = 5'h13;
    speed    = 8'h80;
    send_req = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h93);
    m_seq = 8'h01;
    frame_run("t1", 0, 50 * Baud);
    check_eq("t1_seq", seq, 8'h01);

    // Coalesced requests give one gapless follow-up frame
    repeat (5) tick();
    send_req = 1'b1;
    push_frame(m_seq, 5'h13, 8'h80);
    push_frame(m_seq + 8'd1, 5'h13, 8'h80);
    m_seq = m_seq + 8'd2;
    frame_run("t2", 1, 100 * Baud);
    check_eq("t2_seq", seq, m_seq);

    // Status change triggers a frame; a mid-frame change is in the next one
    repeat (5) tick();
    status = 5'h01;
    push_frame(m_seq, 5'h01, 8'h80);
    push_frame(m_seq + 8'd1, 5'h02, 8'h80);
    m_seq = m_seq + 8'd2;
    frame_run("t3", 2, 100 * Baud);
    check_eq("t3_seq", seq, m_seq);

    // Reset in the middle of byte 2
    repeat (5) tick();
    send_req = 1'b1;
    push_frame(m_seq, 5'h02, 8'h80);
    tick();
    send_req = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    #1;
    check_eq("mid_rst_tx", tx, 1'b1);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_seq", seq, 8'h00);
    exp_q.delete();
    status = 5'h00;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    check_eq("post_rst_idle", busy, 1'b0);
    send_req = 1'b1;
    push_frame(8'h00, 5'h00, 8'h80);
    m_seq = 8'h01;
    frame_run("t5", 0, 50 * Baud);
    check_eq("t5_seq", seq, 8'h01);

    // 255 more frames with random content, then the 257th wraps to seq 00
    for (int i = 0; i < 255; i++) begin
      tick();
      status   = 5'($urandom);
      speed    = 8'($urandom);
      send_req = 1'b1;
      push_frame(m_seq, status, speed);
      m_seq = m_seq + 8'd1;
      frame_run("bulk", 0, 50 * Baud);
    end
    check_eq("wrap_seq", seq, 8'h00);
    tick();
    status   = 5'h1F;
    speed    = 8'h3C;
    send_req = 1'b1;
    push_frame(m_seq, 5'h1F, 8'h3C);
    frame_run("t257", 0, 50 * Baud);
    check_eq("t257_seq", seq, 8'h01);

    repeat (10) tick();
    check_eq("sb_drain", exp_q.size(), 0);
    check_eq("per_rises", nrise >= 3, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
